// File: rtl/eeg_obuf_ser.sv
// Output buffer: DEPTH-word FIFO feeding a slice serialiser toward the pads.
// Optional OBUF_TRAILER_EN appends a word-count beat after each packet.
`timescale 1ns/1ps
module eeg_obuf_ser #(
  parameter int IN_DW     = 32,
  parameter int OUT_DW    = 8,
  parameter int DEPTH     = 16,
  parameter int RDY_THR   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ACC_DAT_RDY,
  input  logic              ACC_OUT_VLD,
  input  logic              ACC_OUT_LST,
  input  logic [IN_DW-1:0]  ACC_OUT_DAT,
  output logic              ACC_OUT_RDY,
  output logic              BUF_DAT_RDY,
  output logic              BUF_OUT_VLD,
  output logic              BUF_OUT_LST,
  output logic [OUT_DW-1:0] BUF_OUT_DAT,
  input  logic              BUF_OUT_RDY,
  output logic [$clog2(DEPTH):0] BUF_LEVEL
);

  localparam int R  = IN_DW / OUT_DW;
  localparam int AW = $clog2(DEPTH);
  localparam int BW = (R > 1) ? $clog2(R) : 1;
  localparam logic [AW:0]   DEP   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   THR   = (AW+1)'(RDY_THR);
  localparam logic [BW-1:0] LASTB = BW'(R - 1);

`ifdef OBUF_TRAILER_EN
  localparam bit TEN = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, TRAILER} st_t;
`else
  localparam bit TEN = 1'b0;
  typedef enum logic [1:0] {IDLE, SHIFT} st_t;
`endif

  logic [IN_DW:0]    mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       count;
  logic              full, empty, push, pop;
  logic [IN_DW:0]    head;

  st_t               state, state_n;
  logic [BW-1:0]     beat, beat_n;
  logic [IN_DW-1:0]  word, word_n;
  logic              wlst, wlst_n;
  logic              vld_q, vld_n;
  logic              olst_q, olst_n;
  logic [OUT_DW-1:0] odat_q, odat_n;

  function automatic logic [OUT_DW-1:0] slice(
    input logic [IN_DW-1:0] w,
    input logic [BW-1:0]    k
  );
    int sh;
    if (MSB_FIRST != 0) sh = (R - 1 - int'(k)) * OUT_DW;
    else                sh = int'(k) * OUT_DW;
    return OUT_DW'(w >> sh);
  endfunction

  assign full  = (count == DEP);
  assign empty = (count == '0);
  assign push  = ACC_OUT_VLD & ~full;
  assign head  = mem[rptr];

  assign ACC_OUT_RDY = ~full;
  assign BUF_DAT_RDY = ACC_DAT_RDY & ((DEP - count) >= THR);
  assign BUF_LEVEL   = count;
  assign BUF_OUT_VLD = vld_q;
  assign BUF_OUT_LST = olst_q;
  assign BUF_OUT_DAT = odat_q;

`ifdef OBUF_TRAILER_EN
  logic [OUT_DW-1:0] wcnt;

  always_ff @(posedge clk) begin
    if (rst)
      wcnt <= '0;
    else if (state == TRAILER && BUF_OUT_RDY)
      wcnt <= '0;
    else if (pop)
      wcnt <= wcnt + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {ACC_OUT_LST, ACC_OUT_DAT};
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    beat_n  = beat;
    word_n  = word;
    wlst_n  = wlst;
    vld_n   = vld_q;
    olst_n  = olst_q;
    odat_n  = odat_q;
    case (state)
      IDLE: begin
        vld_n  = 1'b0;
        olst_n = 1'b0;
        if (!empty) pop = 1'b1;
      end
      SHIFT: begin
        if (BUF_OUT_RDY) begin
          if (beat != LASTB) begin
            beat_n = beat + 1'b1;
            odat_n = slice(word, beat + 1'b1);
            olst_n = wlst && !TEN && ((beat + 1'b1) == LASTB);
          end
`ifdef OBUF_TRAILER_EN
          else if (wlst) begin
            // count beat follows the packet; its LST replaces the data LST
            state_n = TRAILER;
            odat_n  = wcnt;
            olst_n  = 1'b1;
          end
`endif
          else if (!empty) begin
            pop = 1'b1;
          end else begin
            state_n = IDLE;
            vld_n   = 1'b0;
            olst_n  = 1'b0;
          end
        end
      end
`ifdef OBUF_TRAILER_EN
      TRAILER: begin
        if (BUF_OUT_RDY) begin
          state_n = IDLE;
          vld_n   = 1'b0;
          olst_n  = 1'b0;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
    if (pop) begin
      state_n = SHIFT;
      word_n  = head[IN_DW-1:0];
      wlst_n  = head[IN_DW];
      beat_n  = '0;
      vld_n   = 1'b1;
      odat_n  = slice(head[IN_DW-1:0], '0);
      olst_n  = (R == 1) && head[IN_DW] && !TEN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      state  <= IDLE;
      beat   <= '0;
      word   <= '0;
      wlst   <= 1'b0;
      vld_q  <= 1'b0;
      olst_q <= 1'b0;
      odat_q <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      state  <= state_n;
      beat   <= beat_n;
      word   <= word_n;
      wlst   <= wlst_n;
      vld_q  <= vld_n;
      olst_q <= olst_n;
      odat_q <= odat_n;
    end
  end

endmodule
